pmem_arbiter: RTL and testbench
===============================

PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 1, extra wait cycles between memory access and response (legal 0..15).
REQ-002 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports ifu_req_valid in 1, ifu_req_ready out 1, ifu_addr in 64: instruction-fetch read request.
REQ-005 SHALL have ports ifu_resp_valid out 1, ifu_rdata out 64: fetch response.
REQ-006 SHALL have ports lsu_req_valid in 1, lsu_req_ready out 1, lsu_wen in 1, lsu_addr in 64, lsu_wdata in 64, lsu_mask in 8: load/store request.
REQ-007 SHALL have ports lsu_resp_valid out 1, lsu_rdata out 64: load/store response.
REQ-008 SHALL have ports mem_raddr out 64, mem_rvalid out 1, mem_rdata in 64, mem_waddr out 64, mem_wdata out 64, mem_mask out 8: physical-memory side (combinational read, masked write).
REQ-009 SHALL have port busy out 1: high whenever state is not IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, WAIT, RESP.
REQ-011 SHALL assert ifu_req_ready/lsu_req_ready only in IDLE, and only for the requester granted that cycle; at most one ready high per cycle.
REQ-012 SHALL accept a request on valid&&ready, latch addr, wen (0 for IFU), wdata, mask and requester id, and go IDLE->ACCESS.
REQ-013 SHALL, in fixed-priority mode, grant LSU over IFU when both valid.
REQ-014 SHALL, in ACCESS for one cycle: on read, drive mem_rvalid=1 and capture mem_rdata into the response register; on write, drive mem_mask=latched mask, response data=0.
REQ-015 SHALL hold mem_rvalid=0 and mem_mask=8'h00 in every state other than ACCESS, so no stray read or write occurs.
REQ-016 SHALL drive mem_raddr, mem_waddr, mem_wdata from the latched request registers at all times.
REQ-017 SHALL go ACCESS->WAIT when LAT>0, staying LAT cycles (counter), else ACCESS->RESP directly.
REQ-018 SHALL in RESP pulse exactly one of ifu_resp_valid/lsu_resp_valid for one cycle with rdata valid, then return to IDLE.
REQ-019 SHALL give accept-to-resp_valid latency of exactly LAT+2 cycles; next accept earliest the cycle after RESP.
REQ-020 SHALL hold ifu_rdata/lsu_rdata at last response value between pulses; no response backpressure exists.
REQ-021 SHALL process an LSU write with lsu_mask=0 normally (access issued with mask 0, response pulsed, rdata 0).
REQ-022 SHALL ignore input changes on non-granted requesters and latched-request inputs after acceptance.

Reset
REQ-023 SHALL on reset low, immediately and asynchronously: state=IDLE, counter=0, all resp_valid=0, mem_rvalid=0, mem_mask=0, rdata/address/data registers=0, round-robin pointer=IFU-last.
REQ-024 SHALL abandon an in-flight request on reset without any response pulse; first accept possible the first clock edge after reset release.

Configuration
REQ-025 SHALL, with macro PMEM_ARB_RR_EN defined, replace fixed priority by round-robin: on simultaneous valid, grant the requester not granted last; pointer updates on each accept.
REQ-026 SHALL, without PMEM_ARB_RR_EN, contain no pointer register and use fixed LSU priority per REQ-013.

Verification
REQ-027 SHALL cover: LAT=1, IFU read addr 0x8000_0000 with mem returning 0x0000_0013_0000_0297 -> ifu_resp_valid pulse 3 cycles after accept, ifu_rdata matches, mem_rvalid high exactly 1 cycle.
REQ-028 SHALL cover: LSU write addr 0x8000_0100, wdata 0xDEAD_BEEF_CAFE_F00D, mask 0x0F -> mem_mask=0x0F for exactly one cycle, lsu_resp_valid pulse with lsu_rdata=0.
REQ-029 SHALL cover: both valid every cycle for 4 transactions -> fixed: LSU,LSU,LSU,LSU; with PMEM_ARB_RR_EN: LSU,IFU,LSU,IFU.
REQ-030 SHALL cover: LAT=0 and LAT=15 back-to-back reads -> latency 2 and 17 cycles, accepts spaced 3 and 18 cycles.
REQ-031 SHALL cover: reset asserted in WAIT of an LSU write -> no lsu_resp_valid, mem_mask=0 and busy=0 immediately, next request served normally.

Source files
------------

// File: rtl/pmem_arbiter.sv
// -----------------------------------------------------------------------------
// pmem_arbiter
//
// Purpose:
//   Two-port arbiter in front of a single physical memory. The instruction
//   fetch unit (IFU) issues reads; the load/store unit (LSU) issues reads or
//   masked writes. One request is served at a time through a small FSM:
//     IDLE   -> accept one request (valid && ready), latch it
//     ACCESS -> one cycle of memory access (read strobe or write mask)
//     WAIT   -> LAT extra cycles (skipped entirely when LAT == 0)
//     RESP   -> one-cycle response pulse to the requester that was served
//   Accept-to-response latency is LAT+2 cycles; the next accept can happen
//   at the earliest in the cycle after RESP.
//
// Configuration:
//   PMEM_ARB_RR_EN  when defined, simultaneous requests are granted
//                   round-robin (the requester not granted last wins).
//                   When undefined, the LSU always wins and no pointer
//                   register exists.
//
// Parameters:
//   LAT             extra wait cycles between access and response (0..15)
//
// Ports:
//   clock           sole clock, all state on the rising edge
//   reset           asynchronous, active-low reset
//   ifu_req_valid/ifu_req_ready/ifu_addr      fetch read request
//   ifu_resp_valid/ifu_rdata                  fetch response
//   lsu_req_valid/lsu_req_ready/lsu_wen/lsu_addr/lsu_wdata/lsu_mask
//                                             load/store request
//   lsu_resp_valid/lsu_rdata                  load/store response
//   mem_raddr/mem_rvalid/mem_rdata            memory read side (combinational)
//   mem_waddr/mem_wdata/mem_mask              memory write side (masked)
//   busy            high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module pmem_arbiter #(
  parameter int unsigned LAT = 1
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [63:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [63:0] ifu_rdata,

  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_wen,
  input  logic [63:0] lsu_addr,
  input  logic [63:0] lsu_wdata,
  input  logic [7:0]  lsu_mask,
  output logic        lsu_resp_valid,
  output logic [63:0] lsu_rdata,

  output logic [63:0] mem_raddr,
  output logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_mask,

  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  // The wait counter is loaded with LAT-1 so that WAIT lasts exactly LAT
  // cycles; clamped so the LAT == 0 build still elaborates cleanly.
  localparam logic [3:0] LAT_M1 = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  waitCnt_q, waitCnt_d;

  logic [63:0] reqAddr_q, reqAddr_d;
  logic [63:0] reqWdata_q, reqWdata_d;
  logic [7:0]  reqMask_q, reqMask_d;
  logic        reqWen_q, reqWen_d;
  logic        reqLsu_q, reqLsu_d;

  logic [63:0] respData_q, respData_d;
  logic [63:0] ifuRdata_q, ifuRdata_d;
  logic [63:0] lsuRdata_q, lsuRdata_d;

  logic        grantIfu;
  logic        grantLsu;
  logic        accept;
  logic [63:0] accessData;

`ifdef PMEM_ARB_RR_EN
  // Remembers who was granted last (1 = LSU); reset state means "IFU last"
  // so the very first contested grant goes to the LSU.
  logic        lastLsu_q, lastLsu_d;

  always_comb begin
    grantLsu = lsu_req_valid;
    if (ifu_req_valid && lsu_req_valid) begin
      grantLsu = ~lastLsu_q;
    end
    grantIfu = ifu_req_valid && !grantLsu;
  end

  always_comb begin
    lastLsu_d = lastLsu_q;
    if (accept) begin
      lastLsu_d = lsu_req_ready;
    end
  end
`else
  // Fixed priority: LSU always beats IFU.
  always_comb begin
    grantLsu = lsu_req_valid;
    grantIfu = ifu_req_valid && !lsu_req_valid;
  end
`endif

  // Ready only ever goes to the single granted requester, and only in IDLE.
  assign ifu_req_ready = (state_q == IDLE) && grantIfu;
  assign lsu_req_ready = (state_q == IDLE) && grantLsu;
  assign accept        = ifu_req_ready || lsu_req_ready;

  // Writes return zero as their response data.
  assign accessData = reqWen_q ? 64'd0 : mem_rdata;

  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    reqAddr_d  = reqAddr_q;
    reqWdata_d = reqWdata_q;
    reqMask_d  = reqMask_q;
    reqWen_d   = reqWen_q;
    reqLsu_d   = reqLsu_q;
    respData_d = respData_q;
    ifuRdata_d = ifuRdata_q;
    lsuRdata_d = lsuRdata_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          reqLsu_d   = lsu_req_ready;
          reqAddr_d  = lsu_req_ready ? lsu_addr : ifu_addr;
          reqWen_d   = lsu_req_ready && lsu_wen;
          reqWdata_d = lsu_req_ready ? lsu_wdata : 64'd0;
          reqMask_d  = lsu_req_ready ? lsu_mask : 8'h00;
          state_d    = ACCESS;
        end
      end

      ACCESS: begin
        // Capture now; the visible rdata outputs only change on the edge
        // that enters RESP so they keep the previous response until then.
        respData_d = accessData;
        if (LAT > 0) begin
          state_d   = WAIT;
          waitCnt_d = LAT_M1;
        end else begin
          state_d = RESP;
          if (reqLsu_q) begin
            lsuRdata_d = accessData;
          end else begin
            ifuRdata_d = accessData;
          end
        end
      end

      WAIT: begin
        if (waitCnt_q == 4'd0) begin
          state_d = RESP;
          if (reqLsu_q) begin
            lsuRdata_d = respData_q;
          end else begin
            ifuRdata_d = respData_q;
          end
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      waitCnt_q  <= 4'd0;
      reqAddr_q  <= 64'd0;
      reqWdata_q <= 64'd0;
      reqMask_q  <= 8'h00;
      reqWen_q   <= 1'b0;
      reqLsu_q   <= 1'b0;
      respData_q <= 64'd0;
      ifuRdata_q <= 64'd0;
      lsuRdata_q <= 64'd0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      reqAddr_q  <= reqAddr_d;
      reqWdata_q <= reqWdata_d;
      reqMask_q  <= reqMask_d;
      reqWen_q   <= reqWen_d;
      reqLsu_q   <= reqLsu_d;
      respData_q <= respData_d;
      ifuRdata_q <= ifuRdata_d;
      lsuRdata_q <= lsuRdata_d;
    end
  end

`ifdef PMEM_ARB_RR_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lastLsu_q <= 1'b0;
    end else begin
      lastLsu_q <= lastLsu_d;
    end
  end
`endif

  // Memory strobes are decoded from state so they drop to zero the instant
  // reset asserts, and can never fire outside the single ACCESS cycle.
  assign mem_rvalid = (state_q == ACCESS) && !reqWen_q;
  assign mem_mask   = ((state_q == ACCESS) && reqWen_q) ? reqMask_q : 8'h00;
  assign mem_raddr  = reqAddr_q;
  assign mem_waddr  = reqAddr_q;
  assign mem_wdata  = reqWdata_q;

  assign ifu_resp_valid = (state_q == RESP) && !reqLsu_q;
  assign lsu_resp_valid = (state_q == RESP) && reqLsu_q;
  assign ifu_rdata      = ifuRdata_q;
  assign lsu_rdata      = lsuRdata_q;

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_pmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pmem_arbiter
//
// Three arbiter instances (LAT = 1, 0, 15) share clock and reset; a behavioural
// memory answers reads combinationally. Each accepted request pushes its
// expected response (requester, data, cycle) onto a scoreboard queue that the
// monitor pops when a response pulse appears.
// -----------------------------------------------------------------------------
module tb_pmem_arbiter;

  localparam int NINST = 3;

`ifdef PMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clock = 1'b0;
  logic rstN;
  int   cyc = 0;

  // Free-running clock and cycle counter used for latency bookkeeping
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  logic        ifuReqValid  [NINST];
  logic        ifuReqReady  [NINST];
  logic [63:0] ifuAddr      [NINST];
  logic        ifuRespValid [NINST];
  logic [63:0] ifuRdata     [NINST];
  logic        lsuReqValid  [NINST];
  logic        lsuReqReady  [NINST];
  logic        lsuWen       [NINST];
  logic [63:0] lsuAddr      [NINST];
  logic [63:0] lsuWdata     [NINST];
  logic [7:0]  lsuMask      [NINST];
  logic        lsuRespValid [NINST];
  logic [63:0] lsuRdata     [NINST];
  logic [63:0] memRaddr     [NINST];
  logic        memRvalid    [NINST];
  logic [63:0] memRdata     [NINST];
  logic [63:0] memWaddr     [NINST];
  logic [63:0] memWdata     [NINST];
  logic [7:0]  memMask      [NINST];
  logic        busy         [NINST];

  function automatic int latOf(input int i);
    if (i == 0) return 1;
    if (i == 1) return 0;
    return 15;
  endfunction

  // Behavioural memory contents
  function automatic logic [63:0] memModel(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 64'h0000_0013_0000_0297;
    return {a[31:0], ~a[31:0]};
  endfunction

  genvar g;
  generate
    for (g = 0; g < NINST; g++) begin : gDut
      localparam int unsigned LATG = (g == 0) ? 1 : ((g == 1) ? 0 : 15);
      pmem_arbiter #(.LAT(LATG)) uDut (
        .clock          (clock),
        .reset          (rstN),
        .ifu_req_valid  (ifuReqValid[g]),
        .ifu_req_ready  (ifuReqReady[g]),
        .ifu_addr       (ifuAddr[g]),
        .ifu_resp_valid (ifuRespValid[g]),
        .ifu_rdata      (ifuRdata[g]),
        .lsu_req_valid  (lsuReqValid[g]),
        .lsu_req_ready  (lsuReqReady[g]),
        .lsu_wen        (lsuWen[g]),
        .lsu_addr       (lsuAddr[g]),
        .lsu_wdata      (lsuWdata[g]),
        .lsu_mask       (lsuMask[g]),
        .lsu_resp_valid (lsuRespValid[g]),
        .lsu_rdata      (lsuRdata[g]),
        .mem_raddr      (memRaddr[g]),
        .mem_rvalid     (memRvalid[g]),
        .mem_rdata      (memRdata[g]),
        .mem_waddr      (memWaddr[g]),
        .mem_wdata      (memWdata[g]),
        .mem_mask       (memMask[g]),
        .busy           (busy[g])
      );
      assign memRdata[g] = memModel(memRaddr[g]);
    end
  endgenerate

  typedef struct {
    int          inst;
    bit          isLsu;
    logic [63:0] data;
    int          cycle;
  } exp_t;

  exp_t        sb[$];
  int          checksTotal = 0;
  int          checksPassed = 0;
  int          respSeen = 0;
  int          respPushed = 0;
  bit          lastLsu [NINST];
  int          rvalidCnt [NINST];
  int          maskCnt [NINST];
  logic [63:0] lastRaddr [NINST];
  logic [63:0] lastWaddr [NINST];
  logic [63:0] lastWdata [NINST];
  logic [7:0]  lastMask [NINST];

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checksTotal++;
    if (actual === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Monitor: memory strobes and response pulses, sampled on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      for (int i = 0; i < NINST; i++) begin
        if (memRvalid[i] === 1'b1) begin
          rvalidCnt[i]++;
          lastRaddr[i] = memRaddr[i];
        end
        if (memMask[i] !== 8'h00) begin
          maskCnt[i]++;
          lastMask[i]  = memMask[i];
          lastWaddr[i] = memWaddr[i];
          lastWdata[i] = memWdata[i];
        end
        if (ifuRespValid[i] === 1'b1 || lsuRespValid[i] === 1'b1) begin
          respSeen++;
          checkOutput("single_resp", 64'(ifuRespValid[i] && lsuRespValid[i]), 64'd0);
          checkOutput("resp_expected", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput("resp_inst", 64'(i), 64'(e.inst));
            checkOutput("resp_is_lsu", 64'(lsuRespValid[i]), 64'(e.isLsu));
            checkOutput("resp_rdata", lsuRespValid[i] ? lsuRdata[i] : ifuRdata[i], e.data);
            checkOutput("resp_cycle", 64'(cyc), 64'(e.cycle));
          end
        end
      end
    end
  end

  // Drive one request (called just after a rising edge); waits for the
  // accept, checks the grant against the bench's arbitration model and
  // pushes the expected response. Returns just after the accepting edge.
  task automatic applyStimulus(input int inst, input bit useIfu, input bit useLsu,
                               input logic [63:0] iAddr, input logic [63:0] lAddr,
                               input bit wen, input logic [63:0] wdata,
                               input logic [7:0] mask, input bit pushResp,
                               output int acceptCycle, output bit grantedLsu);
    bit   expLsu;
    bit   gotIt;
    exp_t e;
    ifuReqValid[inst] = useIfu;
    ifuAddr[inst]     = iAddr;
    lsuReqValid[inst] = useLsu;
    lsuAddr[inst]     = lAddr;
    lsuWen[inst]      = wen;
    lsuWdata[inst]    = wdata;
    lsuMask[inst]     = mask;
    if (useIfu && useLsu) expLsu = RR ? !lastLsu[inst] : 1'b1;
    else                  expLsu = useLsu;
    gotIt       = 1'b0;
    acceptCycle = -1;
    grantedLsu  = 1'b0;
    for (int n = 0; n < 64 && !gotIt; n++) begin
      @(negedge clock);
      if (ifuReqReady[inst] === 1'b1 || lsuReqReady[inst] === 1'b1) gotIt = 1'b1;
    end
    if (!gotIt) begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
    end else begin
      acceptCycle = cyc;
      grantedLsu  = lsuReqReady[inst];
      checkOutput("grant_lsu", 64'(lsuReqReady[inst]), 64'(expLsu));
      checkOutput("grant_ifu", 64'(ifuReqReady[inst]), 64'(!expLsu));
      lastLsu[inst] = expLsu;
      if (pushResp) begin
        e.inst  = inst;
        e.isLsu = expLsu;
        e.data  = expLsu ? (wen ? 64'd0 : memModel(lAddr)) : memModel(iAddr);
        e.cycle = cyc + latOf(inst) + 2;
        sb.push_back(e);
        respPushed++;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic releaseInputs(input int inst);
    ifuReqValid[inst] = 1'b0;
    lsuReqValid[inst] = 1'b0;
  endtask

  task automatic waitDrain();
    for (int n = 0; n < 64 && sb.size() != 0; n++) @(negedge clock);
    if (sb.size() != 0) checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic pulseReset();
    rstN = 1'b0;
    for (int i = 0; i < NINST; i++) lastLsu[i] = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    rstN = 1'b1;
  endtask

  initial begin
    int          acc;
    int          prevAcc;
    int          rv0;
    int          mk0;
    int          relCyc;
    bit          gl;
    logic [3:0]  expSeq;

    for (int i = 0; i < NINST; i++) begin
      ifuReqValid[i] = 1'b0;
      ifuAddr[i]     = 64'd0;
      lsuReqValid[i] = 1'b0;
      lsuWen[i]      = 1'b0;
      lsuAddr[i]     = 64'd0;
      lsuWdata[i]    = 64'd0;
      lsuMask[i]     = 8'h00;
      lastLsu[i]     = 1'b0;
    end
    rstN = 1'b0;
    #2;
    $display("[TB] reset state");
    checkOutput("rst_busy", 64'(busy[0]), 64'd0);
    checkOutput("rst_ifu_resp_valid", 64'(ifuRespValid[0]), 64'd0);
    checkOutput("rst_lsu_resp_valid", 64'(lsuRespValid[0]), 64'd0);
    checkOutput("rst_mem_rvalid", 64'(memRvalid[0]), 64'd0);
    checkOutput("rst_mem_mask", 64'(memMask[0]), 64'd0);
    checkOutput("rst_mem_raddr", memRaddr[0], 64'd0);
    checkOutput("rst_mem_wdata", memWdata[0], 64'd0);
    checkOutput("rst_ifu_rdata", ifuRdata[0], 64'd0);
    checkOutput("rst_lsu_rdata", lsuRdata[0], 64'd0);
    repeat (3) @(posedge clock);
    #1;
    rstN = 1'b1;

    $display("[TB] IFU read, LAT=1");
    rv0 = rvalidCnt[0];
    mk0 = maskCnt[0];
    applyStimulus(0, 1'b1, 1'b0, 64'h8000_0000, 64'd0, 1'b0, 64'd0, 8'h00, 1'b1, acc, gl);
    releaseInputs(0);
    waitDrain();
    checkOutput("ifu_rvalid_cycles", 64'(rvalidCnt[0] - rv0), 64'd1);
    checkOutput("ifu_mask_cycles", 64'(maskCnt[0] - mk0), 64'd0);
    checkOutput("ifu_raddr", lastRaddr[0], 64'h8000_0000);

    $display("[TB] LSU masked write, inputs scrambled after accept");
    rv0 = rvalidCnt[0];
    mk0 = maskCnt[0];
    applyStimulus(0, 1'b0, 1'b1, 64'd0, 64'h8000_0100, 1'b1, 64'hDEAD_BEEF_CAFE_F00D,
                  8'h0F, 1'b1, acc, gl);
    releaseInputs(0);
    lsuAddr[0]  = 64'h1234_5678;
    lsuWdata[0] = 64'h5555_5555_5555_5555;
    lsuMask[0]  = 8'hFF;
    ifuAddr[0]  = 64'hFFFF_0000;
    waitDrain();
    checkOutput("wr_mask_cycles", 64'(maskCnt[0] - mk0), 64'd1);
    checkOutput("wr_rvalid_cycles", 64'(rvalidCnt[0] - rv0), 64'd0);
    checkOutput("wr_mask", 64'(lastMask[0]), 64'h0F);
    checkOutput("wr_waddr", lastWaddr[0], 64'h8000_0100);
    checkOutput("wr_wdata", lastWdata[0], 64'hDEAD_BEEF_CAFE_F00D);
    checkOutput("ifu_rdata_hold", ifuRdata[0], 64'h0000_0013_0000_0297);

    $display("[TB] LSU read then zero-mask write");
    applyStimulus(0, 1'b0, 1'b1, 64'd0, 64'h8000_0400, 1'b0, 64'd0, 8'h00, 1'b1, acc, gl);
    releaseInputs(0);
    waitDrain();
    checkOutput("lsu_rdata_hold", lsuRdata[0], memModel(64'h8000_0400));
    rv0 = rvalidCnt[0];
    mk0 = maskCnt[0];
    applyStimulus(0, 1'b0, 1'b1, 64'd0, 64'h8000_0108, 1'b1, 64'h1111, 8'h00, 1'b1, acc, gl);
    releaseInputs(0);
    waitDrain();
    checkOutput("zmask_mask_cycles", 64'(maskCnt[0] - mk0), 64'd0);
    checkOutput("zmask_rvalid_cycles", 64'(rvalidCnt[0] - rv0), 64'd0);

    $display("[TB] reset during WAIT of an LSU write");
    applyStimulus(0, 1'b0, 1'b1, 64'd0, 64'h8000_0200, 1'b1, 64'hABCD, 8'hF0, 1'b0, acc, gl);
    releaseInputs(0);
    @(posedge clock);
    #1;
    checkOutput("busy_in_wait", 64'(busy[0]), 64'd1);
    rstN = 1'b0;
    lastLsu[0] = 1'b0;
    #1;
    checkOutput("rst_async_busy", 64'(busy[0]), 64'd0);
    checkOutput("rst_async_mask", 64'(memMask[0]), 64'd0);
    checkOutput("rst_async_lsu_resp", 64'(lsuRespValid[0]), 64'd0);
    checkOutput("rst_async_ifu_rdata", ifuRdata[0], 64'd0);
    checkOutput("rst_async_waddr", memWaddr[0], 64'd0);
    repeat (3) @(posedge clock);
    #1;
    rstN = 1'b1;
    relCyc = cyc;
    applyStimulus(0, 1'b0, 1'b1, 64'd0, 64'h8000_0300, 1'b0, 64'd0, 8'h00, 1'b1, acc, gl);
    releaseInputs(0);
    checkOutput("accept_after_reset", 64'(acc), 64'(relCyc));
    waitDrain();

    $display("[TB] both requesters valid for 4 transactions");
    pulseReset();
    expSeq  = RR ? 4'b0101 : 4'b1111;
    prevAcc = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b1, 1'b1, 64'h8000_1000 + 64'(i * 8), 64'h8000_2000 + 64'(i * 8),
                    1'b0, 64'd0, 8'h00, 1'b1, acc, gl);
      checkOutput("arb_seq", 64'(gl), 64'(expSeq[i]));
      if (i > 0) checkOutput("arb_spacing", 64'(acc - prevAcc), 64'(latOf(0) + 3));
      prevAcc = acc;
    end
    releaseInputs(0);
    waitDrain();

    $display("[TB] LAT=0 back-to-back IFU reads");
    applyStimulus(1, 1'b1, 1'b0, 64'h8000_0000, 64'd0, 1'b0, 64'd0, 8'h00, 1'b1, prevAcc, gl);
    applyStimulus(1, 1'b1, 1'b0, 64'h8000_0040, 64'd0, 1'b0, 64'd0, 8'h00, 1'b1, acc, gl);
    releaseInputs(1);
    checkOutput("lat0_spacing", 64'(acc - prevAcc), 64'd3);
    waitDrain();

    $display("[TB] LAT=15 back-to-back LSU reads");
    applyStimulus(2, 1'b0, 1'b1, 64'd0, 64'h8000_0500, 1'b0, 64'd0, 8'h00, 1'b1, prevAcc, gl);
    applyStimulus(2, 1'b0, 1'b1, 64'd0, 64'h8000_0508, 1'b0, 64'd0, 8'h00, 1'b1, acc, gl);
    releaseInputs(2);
    checkOutput("lat15_spacing", 64'(acc - prevAcc), 64'd18);
    waitDrain();

    repeat (4) @(posedge clock);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
    checkOutput("resp_count", 64'(respSeen), 64'(respPushed));

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] global timeout");
  end

endmodule
